// File: rtl/mem_copy_engine.sv
// Bus-master block-copy engine for the shared 16-bit memory bus.
// Copies LEN words src->dst, refusing destinations inside the ROM window.
`timescale 1ns/1ps
module mem_copy_engine #(
    parameter int ROM_WORDS = 16,
    parameter int PTR_W     = 24
) (
    input  logic             clk,
    input  logic             r,
    input  logic             start,
    input  logic [PTR_W-1:0] src,
    input  logic [PTR_W-1:0] dst,
    input  logic [15:0]      len,
    output logic             bus_req,
    input  logic             bus_gnt,
    inout  wire  [15:0]      bus,
    output logic [15:0]      addr,
    output logic [15:0]      saddr,
    output logic             rwe,
    output logic             roe,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [15:0]      remaining
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        READ,
        WRITE,
        DONE
    } state_t;

    state_t           state;
    logic [PTR_W-1:0] src_ptr;
    logic [PTR_W-1:0] dst_ptr;
    logic [PTR_W-1:0] ptr;
    logic [15:0]      data;
    logic [PTR_W:0]   dst_end;
    logic             reject;
    logic             in_read;
    logic             in_write;

    // A copy is refused if it starts in ROM or would run past the top
    // of the address space and wrap back into ROM.
    assign dst_end = {1'b0, dst} + (PTR_W + 1)'(len);
    assign reject  = (dst < PTR_W'(ROM_WORDS)) ||
                     ((len != 16'd0) && (dst_end > {1'b1, {PTR_W{1'b0}}}));

    assign in_read  = (state == READ);
    assign in_write = (state == WRITE);

    // Strobes follow the grant so that losing the bus silences them at once.
    assign roe = in_read && bus_gnt;
    assign rwe = in_write && bus_gnt;
    assign bus = rwe ? data : 16'hzzzz;

    // Segment:offset split of the active pointer.
    assign ptr   = in_write ? dst_ptr : src_ptr;
    assign addr  = {8'h00, ptr[7:0]};
    assign saddr = ptr[PTR_W-1:8];

    // Control FSM with registered handshake and status outputs.
    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            state     <= IDLE;
            src_ptr   <= '0;
            dst_ptr   <= '0;
            data      <= '0;
            bus_req   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            remaining <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        src_ptr <= src;
                        dst_ptr <= dst;
                        err     <= 1'b0;
                        busy    <= 1'b1;
                        if (reject) begin
                            err       <= 1'b1;
                            done      <= 1'b1;
                            remaining <= '0;
                            state     <= DONE;
                        end else if (len == 16'd0) begin
                            done      <= 1'b1;
                            remaining <= '0;
                            state     <= DONE;
                        end else begin
                            remaining <= len;
                            bus_req   <= 1'b1;
                            state     <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (bus_gnt) begin
                        state <= READ;
                    end
                end
                READ: begin
                    if (bus_gnt) begin
                        data  <= bus;
                        state <= WRITE;
                    end else begin
                        state <= REQ;
                    end
                end
                WRITE: begin
                    if (bus_gnt) begin
                        src_ptr   <= src_ptr + PTR_W'(1);
                        dst_ptr   <= dst_ptr + PTR_W'(1);
                        remaining <= remaining - 16'd1;
                        if (remaining == 16'd1) begin
                            bus_req <= 1'b0;
                            done    <= 1'b1;
                            state   <= DONE;
                        end else begin
                            state <= READ;
                        end
                    end else begin
                        state <= REQ;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    bus_req <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed bench for mem_copy_engine with a 64K-word memory model
// addressed by the low 16 bits of segment*256+offset.
`timescale 1ns/1ps
module tb_mem_copy_engine;

    logic        clk = 1'b0;
    logic        r = 1'b1;
    logic        start = 1'b0;
    logic [23:0] src = '0;
    logic [23:0] dst = '0;
    logic [15:0] len = '0;
    logic        bus_req;
    logic        bus_gnt = 1'b0;
    wire  [15:0] bus;
    logic [15:0] addr;
    logic [15:0] saddr;
    logic        rwe;
    logic        roe;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] remaining;

    int total = 0;
    int bad = 0;

    logic [15:0] mem [0:65535];
    logic [23:0] ea;
    logic        pre_we = 1'b0;
    logic [15:0] pre_a = '0;
    logic [15:0] pre_d = '0;
    logic [23:0] wlog [$];
    logic [15:0] ra [$];
    logic [15:0] rs [$];
    int n_roe = 0;
    int n_rwe = 0;
    int n_both = 0;
    int n_req = 0;

    mem_copy_engine dut (
        .clk       (clk),
        .r         (r),
        .start     (start),
        .src       (src),
        .dst       (dst),
        .len       (len),
        .bus_req   (bus_req),
        .bus_gnt   (bus_gnt),
        .bus       (bus),
        .addr      (addr),
        .saddr     (saddr),
        .rwe       (rwe),
        .roe       (roe),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .remaining (remaining)
    );

    always #5 clk = ~clk;

    assign ea  = {saddr, 8'h00} + {8'h00, addr};
    assign bus = roe ? mem[ea[15:0]] : 16'hzzzz;

    // Memory model and activity monitor, sampled on the active edge
    always @(posedge clk) begin
        if (pre_we) mem[pre_a] = pre_d;
        if (rwe) begin
            mem[ea[15:0]] = bus;
            wlog.push_back(ea);
        end
        if (roe) begin
            n_roe++;
            ra.push_back(addr);
            rs.push_back(saddr);
        end
        if (rwe) n_rwe++;
        if (roe && rwe) n_both++;
        if (bus_req) n_req++;
    end

    task automatic preload(input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        pre_a = a;
        pre_d = d;
        pre_we = 1'b1;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        total++;
        if ({bus_req, roe, rwe, busy, done, err} !== 6'b0) begin
            bad++;
            $display("FAIL reset_ctl got=%b exp=000000",
                     {bus_req, roe, rwe, busy, done, err});
        end
        total++;
        if ({addr, saddr, remaining} !== 48'h0) begin
            bad++;
            $display("FAIL reset_vals got=%h exp=0",
                     {addr, saddr, remaining});
        end
        r = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_copy;
        int b_roe;
        int b_rwe;
        int cyc = 0;
        bit seen = 0;
        for (int k = 0; k < 4; k++) preload(16'h0200 + 16'(k), 16'hA000 + 16'(k));
        b_roe = n_roe;
        b_rwe = n_rwe;
        @(negedge clk);
        bus_gnt = 1'b1;
        src = 24'h000200;
        dst = 24'h000400;
        len = 16'd4;
        start = 1'b1;
        for (int i = 1; i <= 30 && !seen; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                cyc = i;
            end
            start = (i == 3);
            if (i == 3) begin
                dst = 24'h000000;
                len = 16'd1;
            end
        end
        start = 1'b0;
        total++;
        if (!seen || cyc != 10) begin
            bad++;
            $display("FAIL copy_latency got=%0d seen=%0d exp=10", cyc, seen);
        end
        total++;
        if (n_roe - b_roe != 4 || n_rwe - b_rwe != 4) begin
            bad++;
            $display("FAIL copy_strobes got roe=%0d rwe=%0d exp=4/4",
                     n_roe - b_roe, n_rwe - b_rwe);
        end
        for (int k = 0; k < 4; k++) begin
            total++;
            if (mem[16'h0400 + 16'(k)] !== 16'hA000 + 16'(k)) begin
                bad++;
                $display("FAIL copy_data[%0d] got=%h exp=%h", k,
                         mem[16'h0400 + 16'(k)], 16'hA000 + 16'(k));
            end
        end
        total++;
        if (remaining !== 16'd0 || err !== 1'b0) begin
            bad++;
            $display("FAIL copy_status got rem=%h err=%b exp=0/0",
                     remaining, err);
        end
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL copy_idle got busy=%b done=%b exp=0/0", busy, done);
        end
    endtask

    task automatic test_reject_rom;
        int b_req = n_req;
        int b_roe = n_roe;
        int b_rwe = n_rwe;
        @(negedge clk);
        src = 24'h000000;
        dst = 24'h00000F;
        len = 16'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++;
        if (done !== 1'b1 || err !== 1'b1) begin
            bad++;
            $display("FAIL rom_reject got done=%b err=%b exp=1/1", done, err);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || err !== 1'b1) begin
            bad++;
            $display("FAIL rom_after got done=%b busy=%b err=%b exp=0/0/1",
                     done, busy, err);
        end
        total++;
        if (n_req != b_req || n_roe != b_roe || n_rwe != b_rwe) begin
            bad++;
            $display("FAIL rom_nobus got req=%0d roe=%0d rwe=%0d exp=0/0/0",
                     n_req - b_req, n_roe - b_roe, n_rwe - b_rwe);
        end
    endtask

    task automatic test_wrap;
        int wb;
        bit seen = 0;
        @(negedge clk);
        dst = 24'hFFFFFE;
        len = 16'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++;
        if (done !== 1'b1 || err !== 1'b1) begin
            bad++;
            $display("FAIL wrap3_reject got done=%b err=%b exp=1/1", done, err);
        end
        preload(16'h0300, 16'hD000);
        preload(16'h0301, 16'hD001);
        wb = wlog.size();
        @(negedge clk);
        src = 24'h000300;
        dst = 24'hFFFFFE;
        len = 16'd2;
        start = 1'b1;
        for (int i = 1; i <= 20 && !seen; i++) begin
            @(negedge clk);
            start = 1'b0;
            seen = done;
        end
        total++;
        if (!seen || err !== 1'b0) begin
            bad++;
            $display("FAIL wrap2_accept got seen=%0d err=%b exp=1/0", seen, err);
        end
        total++;
        if (wlog.size() - wb != 2) begin
            bad++;
            $display("FAIL wrap2_count got=%0d exp=2", wlog.size() - wb);
        end else begin
            total++;
            if (wlog[wb] !== 24'hFFFFFE || wlog[wb+1] !== 24'hFFFFFF) begin
                bad++;
                $display("FAIL wrap2_addr got=%h,%h exp=fffffe,ffffff",
                         wlog[wb], wlog[wb+1]);
            end
        end
        total++;
        if (mem[16'hFFFE] !== 16'hD000 || mem[16'hFFFF] !== 16'hD001) begin
            bad++;
            $display("FAIL wrap2_data got=%h,%h exp=d000,d001",
                     mem[16'hFFFE], mem[16'hFFFF]);
        end
    endtask

    task automatic test_segment_carry;
        int rb;
        bit seen = 0;
        logic [15:0] ea_off [4];
        logic [15:0] ea_seg [4];
        ea_off = '{16'h00FE, 16'h00FF, 16'h0000, 16'h0001};
        ea_seg = '{16'h0000, 16'h0000, 16'h0001, 16'h0001};
        for (int k = 0; k < 4; k++) preload(16'h00FE + 16'(k), 16'hB000 + 16'(k));
        rb = ra.size();
        @(negedge clk);
        src = 24'h0000FE;
        dst = 24'h000500;
        len = 16'd4;
        start = 1'b1;
        for (int i = 1; i <= 30 && !seen; i++) begin
            @(negedge clk);
            start = 1'b0;
            seen = done;
        end
        total++;
        if (!seen || ra.size() - rb != 4) begin
            bad++;
            $display("FAIL seg_reads got seen=%0d reads=%0d exp=1/4",
                     seen, ra.size() - rb);
        end else begin
            for (int k = 0; k < 4; k++) begin
                total++;
                if (ra[rb+k] !== ea_off[k] || rs[rb+k] !== ea_seg[k]) begin
                    bad++;
                    $display("FAIL seg_addr[%0d] got=%h:%h exp=%h:%h", k,
                             rs[rb+k], ra[rb+k], ea_seg[k], ea_off[k]);
                end
            end
        end
        for (int k = 0; k < 4; k++) begin
            total++;
            if (mem[16'h0500 + 16'(k)] !== 16'hB000 + 16'(k)) begin
                bad++;
                $display("FAIL seg_data[%0d] got=%h exp=%h", k,
                         mem[16'h0500 + 16'(k)], 16'hB000 + 16'(k));
            end
        end
    endtask

    task automatic test_grant_drop;
        int wb;
        int rb;
        int cyc = 0;
        bit seen = 0;
        for (int k = 0; k < 4; k++) preload(16'h0600 + 16'(k), 16'hC000 + 16'(k));
        wb = wlog.size();
        rb = ra.size();
        @(negedge clk);
        src = 24'h000600;
        dst = 24'h000700;
        len = 16'd4;
        start = 1'b1;
        for (int i = 1; i <= 40 && !seen; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                seen = 1;
                cyc = i;
            end
            bus_gnt = !(i >= 5 && i <= 7);
            #1;
            if (i >= 5 && i <= 7) begin
                total++;
                if (rwe !== 1'b0 || roe !== 1'b0 || bus_req !== 1'b1) begin
                    bad++;
                    $display("FAIL drop_c%0d got rwe=%b roe=%b req=%b exp=0/0/1",
                             i, rwe, roe, bus_req);
                end
            end
        end
        bus_gnt = 1'b1;
        total++;
        if (!seen || cyc != 15) begin
            bad++;
            $display("FAIL drop_latency got=%0d seen=%0d exp=15", cyc, seen);
        end
        total++;
        if (wlog.size() - wb != 4 || ra.size() - rb != 5) begin
            bad++;
            $display("FAIL drop_counts got w=%0d r=%0d exp=4/5",
                     wlog.size() - wb, ra.size() - rb);
        end else begin
            total++;
            if (ra[rb+2] !== 16'h0001) begin
                bad++;
                $display("FAIL drop_reread got=%h exp=0001", ra[rb+2]);
            end
            for (int k = 0; k < 4; k++) begin
                total++;
                if (wlog[wb+k] !== 24'h000700 + 24'(k)) begin
                    bad++;
                    $display("FAIL drop_waddr[%0d] got=%h exp=%h", k,
                             wlog[wb+k], 24'h000700 + 24'(k));
                end
            end
        end
        for (int k = 0; k < 4; k++) begin
            total++;
            if (mem[16'h0700 + 16'(k)] !== 16'hC000 + 16'(k)) begin
                bad++;
                $display("FAIL drop_data[%0d] got=%h exp=%h", k,
                         mem[16'h0700 + 16'(k)], 16'hC000 + 16'(k));
            end
        end
    endtask

    task automatic test_reset_midcopy;
        int wb;
        int b_req;
        int b_roe;
        int b_rwe;
        for (int k = 0; k < 4; k++) preload(16'h0800 + 16'(k), 16'hE000 + 16'(k));
        wb = wlog.size();
        @(negedge clk);
        bus_gnt = 1'b1;
        src = 24'h000800;
        dst = 24'h000900;
        len = 16'd4;
        start = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        #1;
        total++;
        if (roe !== 1'b1 || addr !== 16'h0002) begin
            bad++;
            $display("FAIL rst_read3 got roe=%b addr=%h exp=1/0002", roe, addr);
        end
        r = 1'b1;
        #1;
        total++;
        if ({bus_req, roe, rwe, busy, done, err} !== 6'b0 ||
            {addr, saddr, remaining} !== 48'h0) begin
            bad++;
            $display("FAIL rst_async got ctl=%b vals=%h exp=0/0",
                     {bus_req, roe, rwe, busy, done, err},
                     {addr, saddr, remaining});
        end
        @(negedge clk);
        r = 1'b0;
        total++;
        if (wlog.size() - wb != 2) begin
            bad++;
            $display("FAIL rst_writes got=%0d exp=2", wlog.size() - wb);
        end
        b_req = n_req;
        b_roe = n_roe;
        b_rwe = n_rwe;
        @(negedge clk);
        dst = 24'h001000;
        len = 16'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++;
        if (done !== 1'b1 || err !== 1'b0) begin
            bad++;
            $display("FAIL len0_done got done=%b err=%b exp=1/0", done, err);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0 || n_req != b_req || n_roe != b_roe || n_rwe != b_rwe) begin
            bad++;
            $display("FAIL len0_nobus got done=%b req=%0d roe=%0d rwe=%0d exp=0/0/0/0",
                     done, n_req - b_req, n_roe - b_roe, n_rwe - b_rwe);
        end
    endtask

    initial begin
        test_reset();
        test_copy();
        test_reject_rom();
        test_wrap();
        test_segment_carry();
        test_grant_drop();
        test_reset_midcopy();
        total++;
        if (n_both != 0) begin
            bad++;
            $display("FAIL strobe_overlap got=%0d exp=0", n_both);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
